// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between two byte-stream requesters, the arbiter and a FIFO.
// The master side holds the requesters and the FIFO full flag. The slave side
// is the arbiter, which drives the grants, ready strobes and FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              vld0;
    logic              vld1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              rdy0;
    logic              rdy1;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;

    modport master (
        output req0, req1, vld0, vld1, data0, data1, w_full,
        input  gnt0, gnt1, rdy0, rdy1, w_en, w_data
    );

    modport slave (
        input  req0, req1, vld0, vld1, data0, data1, w_full,
        output gnt0, gnt1, rdy0, rdy1, w_en, w_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter for a single FIFO write port.
// A grant lasts up to BURST_LEN accepted beats. It also ends early when the
// owner drops its request. Grants hand over back-to-back with no dead cycle.
// While the FIFO is full, no beat is accepted and the burst state is frozen.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
) (
    input  logic              w_clk,
    input  logic              w_rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRV0 = 2'd1,
        SRV1 = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        rr_r;
    logic        next_rr_s;
    logic [7:0]  cnt_r;
    logic [7:0]  next_cnt_s;
    logic        gnt0_r;
    logic        gnt1_r;
    logic        acc0_s;
    logic        acc1_s;
    logic        last_s;

    // Beat acceptance: the owner must request and present valid data while the FIFO has room.
    // Beats are blocked during the reset cycle, so an abandoned burst writes nothing.
    always_comb begin
        acc0_s = (state_r == SRV0) && bus.req0 && bus.vld0 && !bus.w_full && !w_rst;
        acc1_s = (state_r == SRV1) && bus.req1 && bus.vld1 && !bus.w_full && !w_rst;
        last_s = (cnt_r == LAST_BEAT);
    end

    // Next-state logic covers the arbitration choice, burst termination and the beat counter.
    always_comb begin
        next_state_s = state_r;
        next_rr_s    = rr_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                next_cnt_s = 8'd0;
                if (bus.req0 && bus.req1) begin
                    next_state_s = rr_r ? SRV0 : SRV1;
                end else if (bus.req0) begin
                    next_state_s = SRV0;
                end else if (bus.req1) begin
                    next_state_s = SRV1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SRV0: begin
                if (bus.w_full) begin
                    next_state_s = SRV0;
                end else if (!bus.req0 || (acc0_s && last_s)) begin
                    next_rr_s  = 1'b0;
                    next_cnt_s = 8'd0;
                    if (bus.req1) begin
                        next_state_s = SRV1;
                    end else if (bus.req0) begin
                        next_state_s = SRV0;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else if (acc0_s) begin
                    next_cnt_s = cnt_r + 8'd1;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            SRV1: begin
                if (bus.w_full) begin
                    next_state_s = SRV1;
                end else if (!bus.req1 || (acc1_s && last_s)) begin
                    next_rr_s  = 1'b1;
                    next_cnt_s = 8'd0;
                    if (bus.req0) begin
                        next_state_s = SRV0;
                    end else if (bus.req1) begin
                        next_state_s = SRV1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else if (acc1_s) begin
                    next_cnt_s = cnt_r + 8'd1;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = 8'd0;
            end
        endcase
    end

    // State, pointer, counter and grant registers. After reset, requester 0 has priority.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_r <= IDLE;
            rr_r    <= 1'b1;
            cnt_r   <= 8'd0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            rr_r    <= next_rr_s;
            cnt_r   <= next_cnt_s;
            gnt0_r  <= (next_state_s == SRV0);
            gnt1_r  <= (next_state_s == SRV1);
        end
    end

    assign bus.gnt0   = gnt0_r;
    assign bus.gnt1   = gnt1_r;
    assign bus.rdy0   = gnt0_r && bus.req0 && !bus.w_full && !w_rst;
    assign bus.rdy1   = gnt1_r && bus.req1 && !bus.w_full && !w_rst;
    assign bus.w_en   = acc0_s || acc1_s;
    assign bus.w_data = acc0_s ? bus.data0 :
                        acc1_s ? bus.data1 : {DATA_W{1'b0}};
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte-stream data width.
REQ-002 SHALL have parameter BURST_LEN, default 16, maximum beats per grant (legal 1..255).
REQ-003 SHALL have port w_clk  input  1  single clock for all logic, shared with the FIFO write side.
REQ-004 SHALL have port w_rst  input  1  reset, synchronous to w_clk, active-high.
REQ-005 SHALL have ports req0/req1  input  1  requester N wants the FIFO write port.
REQ-006 SHALL have ports vld0/vld1  input  1  requester N presents a beat on dataN.
REQ-007 SHALL have ports data0/data1  input  DATA_W  requester N write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  registered; requester N owns the write port.
REQ-009 SHALL have ports rdy0/rdy1  output  1  combinational; rdyN = gntN & reqN & ~w_full.
REQ-010 SHALL have port w_en  output  1  combinational FIFO write strobe.
REQ-011 SHALL have port w_data  output  DATA_W  combinational FIFO write data.
REQ-012 SHALL have port w_full  input  1  FIFO full flag, already in w_clk domain.

Function
REQ-013 SHALL implement FSM states IDLE, SRV0, SRV1; gnt0=1 only in SRV0, gnt1=1 only in SRV1.
REQ-014 SHALL accept a beat in SRVx exactly when reqx & vldx & ~w_full; then w_en=1, w_data=datax, same cycle.
REQ-015 SHALL drive w_en=0 and w_data=0 whenever no beat is accepted.
REQ-016 SHALL keep a last-served pointer rr; rr=0 means requester 0 served last.
REQ-017 IDLE: req0&req1 -> SRV of the requester not equal to rr; single req -> its SRV; none -> stay IDLE.
REQ-018 SHALL take one cycle from request sampled in IDLE to gnt asserted.
REQ-019 SHALL keep an 8-bit beat counter, cleared on every burst start, incremented on each accepted beat only.
REQ-020 SHALL end a burst when a beat is accepted with counter == BURST_LEN-1, or when reqx=0 in SRVx.
REQ-021 On burst end: rr<=x; counter<=0; next state SRV of the other requester if it requests, else SRVx again if reqx=1, else IDLE.
REQ-022 SHALL switch grant between requesters back-to-back, with no IDLE cycle and no dead beat.
REQ-023 While w_full=1: no beat accepted, rdyN=0, counter holds, state holds (burst does not end on full).
REQ-024 SHALL never assert gnt0 and gnt1 together, nor w_en outside SRV0/SRV1.
REQ-025 Requester dropping reqx mid-burst SHALL have no beat accepted in that cycle, even with vldx=1.

Reset
REQ-026 On w_rst=1 at a w_clk edge: state<=IDLE, gnt0=gnt1=0, counter<=0, rr<=1 (requester 0 first).
REQ-027 During and after reset, rdy0=rdy1=0, w_en=0, w_data=0 until a grant is issued.
REQ-028 Reset mid-burst SHALL abandon the burst; no beat is written in the reset cycle or the cycle after.

Verification
REQ-029 Only req0=vld0=1, data0 counting 0,1,2..., w_full=0, BURST_LEN=16 -> gnt0 one cycle after req0, w_en writes 0..15, then SRV0 re-granted with no gap, 16..31 follow.
REQ-030 req0=req1=1 from reset -> 16 beats from data0, then gnt1 the next cycle with 16 beats from data1, then back to requester 0; gnt0 and gnt1 never overlap.
REQ-031 w_full=1 for 5 cycles after beat 4 of a burst -> w_en=0 and rdy0=0 for those 5 cycles; the burst still totals exactly 16 beats.
REQ-032 req1 deasserted after 3 accepted beats while req0=1 -> gnt1 falls and gnt0 rises the next cycle; requester 1 got 3 beats.
REQ-033 w_rst pulsed during beat 7 of an SRV1 burst with both requesting -> gnt=0 and w_en=0 next cycle; after release, requester 0 is granted first.
REQ-034 Arbiter driving the fifo instance (w_clk 20 ns), both requesters streaming -> exactly 256 writes until w_full; w_full=1 with w_en=0 thereafter; read-side data order matches grant order.
